mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared pipeline constants for the multiply/divide unit: op encodings,
// default latencies, state type and the divide helpers.
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic {S_IDLE, S_RUN} mdu_state_e;

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to
    // 0x80000000 with remainder 0. Returns {remainder, quotient}.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        mag_a = a[31] ? -a : a;
        mag_b = b[31] ? -b : b;
        if (mag_b == 32'd0) mag_b = 32'd1;
        q = mag_a / mag_b;
        r = mag_a % mag_b;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = (b == 32'd0) ? 32'd1 : b;
        return {a % d, a / d};
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: computes the result at the accepting edge, holds it
// pending for a fixed busy period, then commits it to HI/LO.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic [3:0]  E_MDU_Op,
    input  logic        E_MDU_Start,
    output logic        E_MDU_Busy,
    output logic [31:0] E_MDU_Out
);

    mdu_state_e  state, state_next;
    logic [31:0] count, count_next;
    logic [31:0] hi, hi_next;
    logic [31:0] lo, lo_next;
    logic [63:0] pend, pend_next;
    logic        pend_wr, pend_wr_next;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        quot_s;
    logic [63:0]        quot_u;

    assign prod_s = $signed({{32{E_MDU_A[31]}}, E_MDU_A}) * $signed({{32{E_MDU_B[31]}}, E_MDU_B});
    assign prod_u = {32'd0, E_MDU_A} * {32'd0, E_MDU_B};
    assign quot_s = div_signed(E_MDU_A, E_MDU_B);
    assign quot_u = div_unsigned(E_MDU_A, E_MDU_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            hi      <= hi_next;
            lo      <= lo_next;
            pend    <= pend_next;
            pend_wr <= pend_wr_next;
        end
    end

    // Starts are only honoured in IDLE; a zero divisor runs the full period
    // but suppresses the commit.
    always_comb begin
        state_next   = state;
        count_next   = count;
        hi_next      = hi;
        lo_next      = lo;
        pend_next    = pend;
        pend_wr_next = pend_wr;
        case (state)
            S_IDLE: begin
                if (E_MDU_Start) begin
                    case (E_MDU_Op)
                        OP_MULT: begin
                            pend_next    = prod_s;
                            pend_wr_next = 1'b1;
                            count_next   = 32'(MULT_CYCLES);
                            state_next   = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_next    = prod_u;
                            pend_wr_next = 1'b1;
                            count_next   = 32'(MULT_CYCLES);
                            state_next   = S_RUN;
                        end
                        OP_DIV: begin
                            pend_next    = quot_s;
                            pend_wr_next = (E_MDU_B != 32'd0);
                            count_next   = 32'(DIV_CYCLES);
                            state_next   = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_next    = quot_u;
                            pend_wr_next = (E_MDU_B != 32'd0);
                            count_next   = 32'(DIV_CYCLES);
                            state_next   = S_RUN;
                        end
                        OP_MTHI: hi_next = E_MDU_A;
                        OP_MTLO: lo_next = E_MDU_A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (count <= 32'd1) begin
                    state_next   = S_IDLE;
                    count_next   = 32'd0;
                    pend_wr_next = 1'b0;
                    if (pend_wr) begin
                        hi_next = pend[63:32];
                        lo_next = pend[31:0];
                    end
                end else begin
                    count_next = count - 32'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign E_MDU_Busy = (state == S_RUN);

    always_comb begin
        E_MDU_Out = 32'd0;
        if (E_MDU_Op == OP_MFHI) E_MDU_Out = hi;
        else if (E_MDU_Op == OP_MFLO) E_MDU_Out = lo;
    end

endmodule
